// File: rtl/extend.sv
// Immediate-extension unit: sign-extends Instr[31:7] into a 32-bit I/S/B/J immediate.
// Latency: out is combinational (0 cycles); out_q/out_valid are registered (1 cycle).
// Backpressure: none; in_valid is a capture strobe and every strobed cycle is captured.
// Optional build macro EXTEND_UTYPE_EN adds the utype input (U-type override, {a[24:5],12'b0}).
module extend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [24:0] a,
    input  logic [1:0]  ImmSrc,
    input  logic        in_valid,
`ifdef EXTEND_UTYPE_EN
    input  logic        utype,
`endif
    output logic [31:0] out,
    output logic [31:0] out_q,
    output logic        out_valid
);

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    logic        sgn;
    logic [31:0] imm;
    logic [31:0] imm_d;
    logic [31:0] imm_q;
    logic        valid_d;
    logic        valid_q;

    // a[k] holds Instr[k+7], so Instr[31] (the sign bit) is a[24].
    assign sgn = a[24];

    // Format decode: pure bit selection and sign replication, no arithmetic.
    always_comb begin
        imm = 32'h0000_0000;
        unique case (ImmSrc)
            IMM_I:   imm = {{20{sgn}}, a[24:13]};
            IMM_S:   imm = {{20{sgn}}, a[24:18], a[4:0]};
            IMM_B:   imm = {{20{sgn}}, a[0], a[23:18], a[4:1], 1'b0};
            IMM_J:   imm = {{12{sgn}}, a[12:5], a[13], a[23:14], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
`ifdef EXTEND_UTYPE_EN
        // U-type wins over ImmSrc so the decoder need not spend a fifth code.
        if (utype) begin
            imm = {a[24:5], 12'b0};
        end
`endif
    end

    assign out = imm;

    // Next state: capture on strobe, otherwise hold data and drop valid.
    always_comb begin
        imm_d   = imm_q;
        valid_d = 1'b0;
        if (in_valid) begin
            imm_d   = imm;
            valid_d = 1'b1;
        end
    end

    // Registered copy; synchronous reset takes priority over a capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            imm_q   <= imm_d;
            valid_q <= valid_d;
        end
    end

    assign out_q     = imm_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_extend.sv
// Directed bench for extend: table of combinational vectors plus registered-path sequences.
// Latency: checks out after settle, out_q/out_valid 1 ns after each rising edge.
// Backpressure: not applicable; stimulus is driven on the falling edge.
module tb_extend;

    logic        clk;
    logic        rst_n;
    logic [24:0] a;
    logic [1:0]  ImmSrc;
    logic        in_valid;
`ifdef EXTEND_UTYPE_EN
    logic        utype;
`endif
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;

    int checks;
    int failures;

    extend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .ImmSrc    (ImmSrc),
        .in_valid  (in_valid),
`ifdef EXTEND_UTYPE_EN
        .utype     (utype),
`endif
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  src;
        logic [24:0] a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then let one rising edge pass and sample 1 ns later.
    task automatic step(input logic rn, input logic iv, input logic [1:0] src, input logic [24:0] av);
        @(negedge clk);
        rst_n    = rn;
        in_valid = iv;
        ImmSrc   = src;
        a        = av;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ImmSrc   = 2'b00;
        a        = 25'h0;
`ifdef EXTEND_UTYPE_EN
        utype    = 1'b0;
`endif

        vecs[0]  = '{"I_zero",     2'b00, 25'h000_000A, 32'h0000_0000};
        vecs[1]  = '{"I_ones",     2'b00, 25'h1FF_FFFF, 32'hFFFF_FFFF};
        vecs[2]  = '{"I_signonly", 2'b00, 25'h100_0000, 32'hFFFF_F800};
        vecs[3]  = '{"I_maxpos",   2'b00, 25'h0FF_E000, 32'h0000_07FF};
        vecs[4]  = '{"S_neg",      2'b01, 25'h1FF_FFEA, 32'hFFFF_FFEA};
        vecs[5]  = '{"S_low5",     2'b01, 25'h000_001F, 32'h0000_001F};
        vecs[6]  = '{"B_pos",      2'b10, 25'h000_000A, 32'h0000_000A};
        vecs[7]  = '{"B_bit11",    2'b10, 25'h000_0001, 32'h0000_0800};
        vecs[8]  = '{"B_signonly", 2'b10, 25'h100_0000, 32'hFFFF_F000};
        vecs[9]  = '{"J_neg",      2'b11, 25'h1FF_FFEA, 32'hFFFF_FFFE};
        vecs[10] = '{"J_bit11",    2'b11, 25'h000_2000, 32'h0000_0800};
        vecs[11] = '{"J_bit12",    2'b11, 25'h000_0020, 32'h0000_1000};

        // Combinational table, applied while reset is held (reset must not affect out).
        for (int i = 0; i < 12; i++) begin
            ImmSrc = vecs[i].src;
            a      = vecs[i].a;
            #2;
            check32(vecs[i].name, out, vecs[i].exp);
        end
        ImmSrc = 2'b11;
        a      = 25'h000_4000;
        #2;
        check32("J_bit1", out, 32'h0000_0002);

        // Reset held for two edges.
        step(1'b0, 1'b0, 2'b00, 25'h0);
        step(1'b0, 1'b0, 2'b00, 25'h0);
        check32("rst_out_q", out_q, 32'h0);
        check1("rst_out_valid", out_valid, 1'b0);

        // Release with a capture of the S vector.
        step(1'b1, 1'b1, 2'b01, 25'h1FF_FFEA);
        check32("cap_S_q", out_q, 32'hFFFF_FFEA);
        check1("cap_S_valid", out_valid, 1'b1);

        // Back-to-back capture of the B vector.
        step(1'b1, 1'b1, 2'b10, 25'h000_000A);
        check32("b2b_B_q", out_q, 32'h0000_000A);
        check1("b2b_B_valid", out_valid, 1'b1);

        // Strobe low with changed inputs: data holds for two edges, valid drops.
        step(1'b1, 1'b0, 2'b00, 25'h1FF_FFFF);
        check32("hold1_q", out_q, 32'h0000_000A);
        check1("hold1_valid", out_valid, 1'b0);
        step(1'b1, 1'b0, 2'b11, 25'h1FF_FFEA);
        check32("hold2_q", out_q, 32'h0000_000A);
        check1("hold2_valid", out_valid, 1'b0);

        // Reset wins over a simultaneous strobe.
        step(1'b0, 1'b1, 2'b11, 25'h1FF_FFEA);
        check32("rst_pri_q", out_q, 32'h0);
        check1("rst_pri_valid", out_valid, 1'b0);

        // Deassert reset with strobe held: capture on the first non-reset edge.
        step(1'b1, 1'b1, 2'b11, 25'h1FF_FFEA);
        check32("post_rst_q", out_q, 32'hFFFF_FFFE);
        check1("post_rst_valid", out_valid, 1'b1);

`ifdef EXTEND_UTYPE_EN
        @(negedge clk);
        utype = 1'b1;
        a     = 25'h157_9BC0;
        for (int s = 0; s < 4; s++) begin
            ImmSrc = s[1:0];
            #1;
            check32("U_override", out, 32'hABCD_E000);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check32("U_cap_q", out_q, 32'hABCD_E000);
        utype = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ImmSrc = vecs[i].src;
            a      = vecs[i].a;
            #1;
            check32(vecs[i].name, out, vecs[i].exp);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
